// File: rtl/writeback_arbiter_pkg.sv
// Shared core definitions for the writeback path: register-file geometry and
// result-source encoding.
package writeback_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int REG_COUNT = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_sel_e;

endpackage

// File: rtl/writeback_arbiter_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register, set at
// issue, cleared on register-file write, with combinational busy queries.
module wb_scoreboard
    import writeback_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     issue_valid,
    input  reg_idx_t issue_dst,
    input  logic     flush,
    input  logic     clr_valid,
    input  reg_idx_t clr_dst,
    input  reg_idx_t ia,
    input  reg_idx_t ib,
    output logic     busy_a,
    output logic     busy_b
);

    logic [REG_COUNT-1:0] pending_q;
    logic [REG_COUNT-1:0] pending_d;
    logic [REG_COUNT-1:0] set_mask;
    logic [REG_COUNT-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_dst != '0) begin
            set_mask = REG_COUNT'(1) << issue_dst;
        end
        if (clr_valid) begin
            clr_mask = REG_COUNT'(1) << clr_dst;
        end
        // Set is OR-ed in last so it wins over both a clear and a flush.
        if (flush) begin
            pending_d = set_mask;
        end else begin
            pending_d = (pending_q & ~clr_mask) | set_mask;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        busy_a = (ia != '0) && pending_q[ia];
        busy_b = (ib != '0) && pending_q[ib];
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Two-source writeback arbiter (LSU priority with ALU starvation guard) driving
// a registered register-file write port and a pending-destination scoreboard.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 aluValid,
    input  logic [REG_IDX_W-1:0] aluDst,
    input  logic [XLEN-1:0]      aluData,
    output logic                 aluReady,
    input  logic                 lsuValid,
    input  logic [REG_IDX_W-1:0] lsuDst,
    input  logic [XLEN-1:0]      lsuData,
    output logic                 lsuReady,
    output logic [REG_IDX_W-1:0] dst,
    output logic [XLEN-1:0]      dataIn,
    output logic                 writeEnable,
    input  logic                 issueValid,
    input  logic [REG_IDX_W-1:0] issueDst,
    input  logic                 flush,
    input  logic [REG_IDX_W-1:0] ia,
    input  logic [REG_IDX_W-1:0] ib,
    output logic                 busyA,
    output logic                 busyB
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]     starve_q, starve_d;
    logic                 we_q, we_d;
    reg_idx_t             dst_q, dst_d;
    logic [XLEN-1:0]      data_q, data_d;
    logic                 grant_alu, grant_lsu, xfer;
    src_sel_e             sel;
    reg_idx_t             acc_dst;
    logic [XLEN-1:0]      acc_data;

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (rst_n) begin
            if (aluValid && lsuValid) begin
                if (starve_q == STARVE_MAX) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else begin
                grant_alu = aluValid;
                grant_lsu = lsuValid;
            end
        end
        xfer = grant_alu | grant_lsu;
        sel  = grant_alu ? SRC_ALU : SRC_LSU;
    end

    always_comb begin
        starve_d = '0;
        if (aluValid && !grant_alu) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    always_comb begin
        acc_dst  = (sel == SRC_ALU) ? aluDst  : lsuDst;
        acc_data = (sel == SRC_ALU) ? aluData : lsuData;
        we_d     = xfer && (acc_dst != '0);
        dst_d    = xfer ? acc_dst  : dst_q;
        data_d   = xfer ? acc_data : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
            we_q     <= 1'b0;
            dst_q    <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            dst_q    <= dst_d;
            data_q   <= data_d;
        end
    end

    assign aluReady    = grant_alu;
    assign lsuReady    = grant_lsu;
    assign writeEnable = we_q;
    assign dst         = dst_q;
    assign dataIn      = data_q;

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issueValid),
        .issue_dst   (issueDst),
        .flush       (flush),
        .clr_valid   (we_q),
        .clr_dst     (dst_q),
        .ia          (ia),
        .ib          (ib),
        .busy_a      (busyA),
        .busy_b      (busyB)
    );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        aluValid, lsuValid, issueValid, flush;
    logic [4:0]  aluDst, lsuDst, issueDst, ia, ib;
    logic [31:0] aluData, lsuData;
    logic        aluReady, lsuReady, writeEnable, busyA, busyB;
    logic [4:0]  dst;
    logic [31:0] dataIn;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.XLEN(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .aluValid(aluValid), .aluDst(aluDst), .aluData(aluData), .aluReady(aluReady),
        .lsuValid(lsuValid), .lsuDst(lsuDst), .lsuData(lsuData), .lsuReady(lsuReady),
        .dst(dst), .dataIn(dataIn), .writeEnable(writeEnable),
        .issueValid(issueValid), .issueDst(issueDst), .flush(flush),
        .ia(ia), .ib(ib), .busyA(busyA), .busyB(busyB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        aluValid = 1'b1; aluDst = 5'd1; aluData = 32'h1111_1111;
        lsuValid = 1'b1; lsuDst = 5'd2; lsuData = 32'h2222_2222;
        #1;
        tests++; if (aluReady !== 1'b0) begin fails++; $display("FAIL rst_aluReady got %b exp 0", aluReady); end
        tests++; if (lsuReady !== 1'b0) begin fails++; $display("FAIL rst_lsuReady got %b exp 0", lsuReady); end
        tick(); tick();
        aluValid = 1'b0; lsuValid = 1'b0; rst_n = 1'b1;
        #1;
        tests++; if (writeEnable !== 1'b0) begin fails++; $display("FAIL rst_we got %b exp 0", writeEnable); end
        tests++; if (dst !== 5'd0) begin fails++; $display("FAIL rst_dst got %0d exp 0", dst); end
        tests++; if (dataIn !== 32'h0) begin fails++; $display("FAIL rst_data got %h exp 0", dataIn); end
        tick();
        tests++; if (writeEnable !== 1'b0) begin fails++; $display("FAIL rst_discard_we got %b exp 0", writeEnable); end
    endtask

    task automatic test_alu_only();
        aluValid = 1'b1; aluDst = 5'd5; aluData = 32'hDEAD_BEEF;
        #1;
        tests++; if (aluReady !== 1'b1) begin fails++; $display("FAIL alu_ready got %b exp 1", aluReady); end
        tests++; if (lsuReady !== 1'b0) begin fails++; $display("FAIL alu_lsuReady got %b exp 0", lsuReady); end
        tick();
        aluValid = 1'b0;
        tests++; if (writeEnable !== 1'b1) begin fails++; $display("FAIL alu_we got %b exp 1", writeEnable); end
        tests++; if (dst !== 5'd5) begin fails++; $display("FAIL alu_dst got %0d exp 5", dst); end
        tests++; if (dataIn !== 32'hDEAD_BEEF) begin fails++; $display("FAIL alu_data got %h exp deadbeef", dataIn); end
        tick();
        tests++; if (writeEnable !== 1'b0) begin fails++; $display("FAIL idle_we got %b exp 0", writeEnable); end
        tests++; if (dst !== 5'd5) begin fails++; $display("FAIL idle_dst_hold got %0d exp 5", dst); end
        tests++; if (dataIn !== 32'hDEAD_BEEF) begin fails++; $display("FAIL idle_data_hold got %h exp deadbeef", dataIn); end
    endtask

    task automatic test_starvation();
        logic       exp_alu;
        logic [4:0] exp_dst;
        aluValid = 1'b1; aluDst = 5'd10; aluData = 32'hAAAA_0000;
        lsuValid = 1'b1; lsuDst = 5'd11; lsuData = 32'h5555_0000;
        for (int c = 0; c < 6; c++) begin
            exp_alu = (c == 3);
            exp_dst = exp_alu ? 5'd10 : 5'd11;
            #1;
            tests++; if (aluReady !== exp_alu) begin fails++; $display("FAIL starve_alu c%0d got %b exp %b", c, aluReady, exp_alu); end
            tests++; if (lsuReady !== !exp_alu) begin fails++; $display("FAIL starve_lsu c%0d got %b exp %b", c, lsuReady, !exp_alu); end
            tick();
            tests++; if (dst !== exp_dst) begin fails++; $display("FAIL starve_dst c%0d got %0d exp %0d", c, dst, exp_dst); end
        end
        aluValid = 1'b0; lsuValid = 1'b0;
        tick();
    endtask

    task automatic test_scoreboard_clear();
        issueValid = 1'b1; issueDst = 5'd7; ia = 5'd7;
        tick();
        issueValid = 1'b0;
        #1;
        tests++; if (busyA !== 1'b1) begin fails++; $display("FAIL sb_issue7 got %b exp 1", busyA); end
        lsuValid = 1'b1; lsuDst = 5'd7; lsuData = 32'h0000_0777;
        #1;
        tests++; if (lsuReady !== 1'b1) begin fails++; $display("FAIL sb_lsuReady got %b exp 1", lsuReady); end
        tick();
        lsuValid = 1'b0;
        tests++; if (writeEnable !== 1'b1 || dst !== 5'd7) begin fails++; $display("FAIL sb_we7 got we=%b dst=%0d exp we=1 dst=7", writeEnable, dst); end
        tests++; if (busyA !== 1'b1) begin fails++; $display("FAIL sb_busy_during_we got %b exp 1", busyA); end
        tick();
        tests++; if (busyA !== 1'b0) begin fails++; $display("FAIL sb_cleared7 got %b exp 0", busyA); end
    endtask

    task automatic test_set_clear_same();
        issueValid = 1'b1; issueDst = 5'd9; ib = 5'd9;
        tick();
        issueValid = 1'b0;
        aluValid = 1'b1; aluDst = 5'd9; aluData = 32'h0000_0999;
        tick();
        aluValid = 1'b0;
        issueValid = 1'b1; issueDst = 5'd9;
        tests++; if (writeEnable !== 1'b1 || dst !== 5'd9) begin fails++; $display("FAIL same_we9 got we=%b dst=%0d exp we=1 dst=9", writeEnable, dst); end
        tick();
        issueValid = 1'b0;
        tests++; if (busyB !== 1'b1) begin fails++; $display("FAIL same_busy9 got %b exp 1", busyB); end
        aluValid = 1'b1; aluDst = 5'd0; aluData = 32'h1234_5678; ia = 5'd0;
        #1;
        tests++; if (aluReady !== 1'b1) begin fails++; $display("FAIL x0_aluReady got %b exp 1", aluReady); end
        tick();
        aluValid = 1'b0;
        tests++; if (writeEnable !== 1'b0) begin fails++; $display("FAIL x0_we got %b exp 0", writeEnable); end
        tests++; if (busyA !== 1'b0) begin fails++; $display("FAIL x0_busy got %b exp 0", busyA); end
        tests++; if (busyB !== 1'b1) begin fails++; $display("FAIL x0_busy9_kept got %b exp 1", busyB); end
    endtask

    task automatic test_flush();
        issueValid = 1'b1; issueDst = 5'd3;
        tick();
        issueDst = 5'd4;
        tick();
        issueValid = 1'b0; ia = 5'd3; ib = 5'd4;
        #1;
        tests++; if (busyA !== 1'b1 || busyB !== 1'b1) begin fails++; $display("FAIL flush_pre got a=%b b=%b exp a=1 b=1", busyA, busyB); end
        flush = 1'b1; issueValid = 1'b1; issueDst = 5'd4;
        tick();
        flush = 1'b0; issueValid = 1'b0;
        tests++; if (busyA !== 1'b0) begin fails++; $display("FAIL flush_x3 got %b exp 0", busyA); end
        tests++; if (busyB !== 1'b1) begin fails++; $display("FAIL flush_x4 got %b exp 1", busyB); end
    endtask

    task automatic test_reset_mid();
        aluValid = 1'b1; aluDst = 5'd12; aluData = 32'hCAFE_F00D;
        tick();
        rst_n = 1'b0; lsuValid = 1'b1; lsuDst = 5'd13;
        #1;
        tests++; if (aluReady !== 1'b0 || lsuReady !== 1'b0) begin fails++; $display("FAIL mid_ready got a=%b l=%b exp 0 0", aluReady, lsuReady); end
        tick();
        rst_n = 1'b1; aluValid = 1'b0; lsuValid = 1'b0;
        #1;
        tests++; if (writeEnable !== 1'b0) begin fails++; $display("FAIL mid_we got %b exp 0", writeEnable); end
        tests++; if (busyA !== 1'b0 || busyB !== 1'b0) begin fails++; $display("FAIL mid_busy got a=%b b=%b exp 0 0", busyA, busyB); end
        tests++; if (dst !== 5'd0) begin fails++; $display("FAIL mid_dst got %0d exp 0", dst); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; aluValid = 1'b0; lsuValid = 1'b0; issueValid = 1'b0; flush = 1'b0;
        aluDst = '0; lsuDst = '0; issueDst = '0; ia = '0; ib = '0;
        aluData = '0; lsuData = '0;
        #2;
        test_reset();
        test_alu_only();
        test_starvation();
        test_scoreboard_clear();
        test_set_clear_same();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
